// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared types, widths and sizing helper for the seven-segment scan driver
package seg_scan_pkg;
  localparam int SEG_W = 7;
  localparam int PWM_W = 4;
  typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/seg_scan_timer.sv
// seg_scan_timer: slot counter and digit index with blank-end, slot-end and frame-wrap strobes
module seg_scan_timer
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int CW = cw(SCAN_DIV),
  parameter int DW = cw(NUM_DIGITS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          run,
  output logic [CW-1:0] cnt,
  output logic [DW-1:0] dig,
  output logic          blank_end,
  output logic          slot_end,
  output logic          frame_wrap
);
  assign slot_end = cnt == CW'(SCAN_DIV - 1);
  assign frame_wrap = slot_end && dig == DW'(NUM_DIGITS - 1);
  assign blank_end = BLANK_CYCLES != 0 && cnt == CW'(BLANK_CYCLES - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt <= '0;
      dig <= '0;
    end else if (!run) begin
      cnt <= '0;
      dig <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      dig <= frame_wrap ? '0 : dig + 1'b1;
    end else
      cnt <= cnt + 1'b1;
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed seven-segment scanner with blanking, PWM dimming and per-frame snapshot
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter bit SEG_ACTIVE_LOW = 1,
  parameter bit DIG_ACTIVE_LOW = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic [SEG_W*NUM_DIGITS-1:0] seg_in,
  input  logic [PWM_W-1:0]            brightness,
  output logic [SEG_W-1:0]            seg_out,
  output logic [NUM_DIGITS-1:0]       dig_en,
  output logic                        frame_start
);
  localparam int CW = cw(SCAN_DIV);
  localparam int DW = cw(NUM_DIGITS);
  localparam logic [SEG_W-1:0] SEG_OFF = SEG_ACTIVE_LOW ? '1 : '0;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = DIG_ACTIVE_LOW ? '1 : '0;
  localparam state_t SLOT_ST = BLANK_CYCLES == 0 ? ON : BLANK;
  state_t state;
  logic [PWM_W-1:0] pwm_cnt;
  logic [SEG_W*NUM_DIGITS-1:0] shadow;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dig;
  logic blank_end, slot_end, frame_wrap, lit;
  seg_scan_timer #(
    .NUM_DIGITS(NUM_DIGITS),
    .SCAN_DIV(SCAN_DIV),
    .BLANK_CYCLES(BLANK_CYCLES),
    .CW(CW),
    .DW(DW)
  ) u_timer (
    .clk(clk),
    .reset_n(reset_n),
    .run(enable && state != IDLE),
    .cnt(cnt),
    .dig(dig),
    .blank_end(blank_end),
    .slot_end(slot_end),
    .frame_wrap(frame_wrap)
  );
  assign lit = state == ON && (&brightness || pwm_cnt < brightness);
  // outputs follow the pre-edge state; enable loss only blanks them one cycle after IDLE is entered
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      pwm_cnt <= '0;
      shadow <= '0;
      seg_out <= SEG_OFF;
      dig_en <= DIG_OFF;
      frame_start <= 1'b0;
    end else begin
      seg_out <= (lit ? shadow[SEG_W*dig +: SEG_W] : '0) ^ SEG_OFF;
      dig_en <= (lit ? NUM_DIGITS'(1) << dig : '0) ^ DIG_OFF;
      frame_start <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        pwm_cnt <= '0;
      end else
        case (state)
          IDLE: begin
            state <= SLOT_ST;
            shadow <= seg_in;
            frame_start <= 1'b1;
          end
          BLANK: if (blank_end) begin
            state <= ON;
            pwm_cnt <= '0;
          end
          ON: begin
            pwm_cnt <= slot_end ? '0 : pwm_cnt + 1'b1;
            if (slot_end) state <= SLOT_ST;
            if (frame_wrap) begin
              shadow <= seg_in;
              frame_start <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: four parameterisations checked every cycle against a time-based display model
module tb_seg_scan_driver;
  localparam int N = 4;
  localparam int NC = 4;
  localparam int SD[NC] = '{8, 34, 8, 8};
  localparam int BC[NC] = '{2, 2, 2, 0};
  localparam bit AL[NC] = '{1'b1, 1'b1, 1'b0, 1'b1};
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic [7*N-1:0] seg_in = '0;
  logic [3:0] brightness = '0;
  logic [6:0] seg_o[NC], e_seg[NC];
  logic [N-1:0] dig_o[NC], e_dig[NC];
  logic fs_o[NC], e_fs[NC];
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < NC; g++) begin : g_cfg
    localparam logic [6:0] SOFF = AL[g] ? 7'h7F : 7'h00;
    localparam logic [N-1:0] DOFF = AL[g] ? '1 : '0;
    logic run;
    int t;
    logic [6:0] sh[N];
    logic [6:0] m_seg;
    logic [N-1:0] m_dig;
    logic m_fs;
    assign e_seg[g] = m_seg;
    assign e_dig[g] = m_dig;
    assign e_fs[g] = m_fs;
    seg_scan_driver #(
      .NUM_DIGITS(N),
      .SCAN_DIV(SD[g]),
      .BLANK_CYCLES(BC[g]),
      .SEG_ACTIVE_LOW(AL[g]),
      .DIG_ACTIVE_LOW(AL[g])
    ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .enable(enable),
      .seg_in(seg_in),
      .brightness(brightness),
      .seg_out(seg_o[g]),
      .dig_en(dig_o[g]),
      .frame_start(fs_o[g])
    );
    // t = cycles since the current frame began; position in slot decides blank vs lit window
    function automatic logic lit_at(input int tt, input logic [3:0] b);
      int pos;
      pos = tt % SD[g];
      return pos >= BC[g] && (b == 4'd15 || (pos - BC[g]) % 16 < int'(b));
    endfunction
    always @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        run <= 1'b0;
        t <= 0;
        m_seg <= SOFF;
        m_dig <= DOFF;
        m_fs <= 1'b0;
        for (int d = 0; d < N; d++) sh[d] <= '0;
      end else begin
        m_seg <= ((run && lit_at(t, brightness)) ? sh[(t / SD[g]) % N] : 7'h00) ^ SOFF;
        m_dig <= ((run && lit_at(t, brightness)) ? N'(1) << ((t / SD[g]) % N) : '0) ^ DOFF;
        if (!enable) begin
          run <= 1'b0;
          m_fs <= 1'b0;
        end else if (!run || t + 1 == N * SD[g]) begin
          run <= 1'b1;
          t <= 0;
          m_fs <= 1'b1;
          for (int d = 0; d < N; d++) sh[d] <= seg_in[7*d +: 7];
        end else begin
          t <= t + 1;
          m_fs <= 1'b0;
        end
      end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      for (int g = 0; g < NC; g++) begin
        check($sformatf("seg%0d", g), 32'(seg_o[g]), 32'(e_seg[g]));
        check($sformatf("dig%0d", g), 32'(dig_o[g]), 32'(e_dig[g]));
        check($sformatf("fs%0d", g), 32'(fs_o[g]), 32'(e_fs[g]));
        check($sformatf("onehot%0d", g), 32'($countones(AL[g] ? ~dig_o[g] : dig_o[g]) <= 1), 32'd1);
      end
    end
  endtask
  task automatic check_off(input string tag);
    for (int g = 0; g < NC; g++) begin
      check($sformatf("%s_seg%0d", tag, g), 32'(seg_o[g]), AL[g] ? 32'h7F : 32'h0);
      check($sformatf("%s_dig%0d", tag, g), 32'(dig_o[g]), AL[g] ? 32'hF : 32'h0);
      check($sformatf("%s_fs%0d", tag, g), 32'(fs_o[g]), 32'h0);
    end
  endtask
  initial begin
    int fsc;
    #12;
    check_off("rst");
    @(negedge clk);
    reset_n = 1'b1;
    step(5);
    seg_in = {7'h06, 7'h5B, 7'h4F, 7'h66};
    brightness = 4'd15;
    enable = 1'b1;
    step(40);
    fsc = 0;
    for (int i = 0; i < 64; i++) begin
      step(1);
      fsc += int'(fs_o[0]);
    end
    check("fs_period", 32'(fsc), 32'd2);
    step(11);
    seg_in = 28'($urandom);
    step(50);
    brightness = 4'd0;
    step(80);
    brightness = 4'd8;
    step(300);
    for (int i = 0; i < 200; i++) begin
      brightness = 4'($urandom);
      if ($urandom_range(0, 15) == 0) seg_in = 28'($urandom);
      step(1);
    end
    brightness = 4'd15;
    step(13);
    enable = 1'b0;
    step(5);
    enable = 1'b1;
    step(60);
    for (int i = 0; i < 300; i++) begin
      enable = $urandom_range(0, 19) != 0;
      if ($urandom_range(0, 7) == 0) brightness = 4'($urandom);
      if ($urandom_range(0, 15) == 0) seg_in = 28'($urandom);
      step(1);
    end
    brightness = 4'd15;
    enable = 1'b0;
    step(2);
    enable = 1'b1;
    step(5);
    #2 reset_n = 1'b0;
    #1 check_off("arst");
    @(negedge clk);
    reset_n = 1'b1;
    step(80);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed seven-segment scan driver, downstream of the per-digit hex display register slaves. It collects the 7-bit segment patterns of NUM_DIGITS digits and drives one shared segment bus plus per-digit enables. Each digit gets a fixed scan slot with an anti-ghosting blank interval and 4-bit PWM brightness. Patterns are snapshotted once per frame so a digit never tears mid-scan.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (>=1)
- SCAN_DIV, 50000, clk cycles per digit slot (>=2)
- BLANK_CYCLES, 500, leading cycles of each slot with everything off (< SCAN_DIV)
- SEG_ACTIVE_LOW, 1, 1 = segment lit when seg_out bit is 0
- DIG_ACTIVE_LOW, 1, 1 = digit selected when dig_en bit is 0

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- enable  in  1  scan enable; 0 forces all outputs off
- seg_in  in  7*NUM_DIGITS  patterns, digit d at bits [7d+6:7d], bit 0 = segment a, 1 = lit (logical)
- brightness  in  4  PWM duty, 0 = dimmest, 15 = full
- seg_out  out  7  shared segment bus, polarity per SEG_ACTIVE_LOW
- dig_en  out  NUM_DIGITS  digit selects, polarity per DIG_ACTIVE_LOW
- frame_start  out  1  one-cycle pulse when digit 0 slot begins

## Operation
- States: IDLE, BLANK, ON. Internal: slot counter cnt (0..SCAN_DIV-1), digit index dig (0..NUM_DIGITS-1), 4-bit pwm_cnt, shadow pattern register.
- IDLE: cnt=0, dig=0, pwm_cnt=0. enable=1 -> BLANK, cnt=0, dig=0, shadow <= seg_in, frame_start pulses.
- BLANK: cnt < BLANK_CYCLES; all segments and digits off. cnt reaches BLANK_CYCLES-1 -> ON, pwm_cnt=0.
- ON: pwm_cnt increments every cycle, wraps 15->0. Digit dig selected and seg_out = shadow[dig] only when brightness==15 or pwm_cnt < brightness; otherwise all off. brightness sampled every cycle (no snapshot).
- cnt reaches SCAN_DIV-1 -> BLANK, cnt=0, dig+1; dig=NUM_DIGITS-1 wraps to 0 with shadow <= seg_in and frame_start pulse.
- BLANK_CYCLES=0: slot starts directly in ON.
- At most one dig_en bit asserted at any cycle; never during BLANK or IDLE.
- enable=0 in any state -> IDLE next cycle; outputs off from the following cycle. Re-enable restarts at digit 0.
- Polarity applied only at the output register: logical off = seg_out all 1 / dig_en all 1 when active-low.

## Timing
- Reset (async): state IDLE, counters 0, shadow 0; seg_out = off (7'h7F if SEG_ACTIVE_LOW else 0), dig_en = off (all 1 if DIG_ACTIVE_LOW else 0), frame_start=0.
- seg_out, dig_en, frame_start are registered: reflect state/cnt of the previous cycle (1-cycle latency).
- Frame period = NUM_DIGITS*SCAN_DIV cycles; lit window per slot = SCAN_DIV-BLANK_CYCLES cycles, PWM-gated.
- seg_in changes mid-frame take effect at the next frame_start only.
- Simultaneous enable fall and slot wrap: IDLE wins; no frame_start.

## Structure
- Package seg_scan_pkg: state enum (IDLE/BLANK/ON), SEG_W=7, PWM_W=4, helper for clog2 of SCAN_DIV and NUM_DIGITS.
- Sub-module seg_scan_timer: cnt/dig counters with slot-end and frame-wrap strobes; top holds FSM, PWM, shadow and output registers.

## Test plan
Params NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2, active-low both, unless stated.
- Reset held -> seg_out=7'h7F, dig_en=4'hF, frame_start=0; release with enable=0 -> unchanged.
- enable=1, brightness=15, seg_in={7'h06,7'h5B,7'h4F,7'h66} -> frame_start 1 cycle; per slot 2 cycles off then 6 cycles dig_en low on one bit cycling 0..3 with seg_out=~pattern; period 32.
- seg_in changed mid-slot of digit 1 -> digits 1..3 still show old patterns; new values appear after next frame_start.
- brightness=0 -> no digit ever selected; brightness=8, SCAN_DIV=34, BLANK_CYCLES=2 -> exactly 16 lit cycles per slot in 8-on/8-off pattern.
- enable dropped mid-ON -> outputs off 2 cycles later; re-enable -> restarts at digit 0 with frame_start.
- Async reset asserted mid-ON -> outputs off immediately (no clock edge); SEG_ACTIVE_LOW=0, DIG_ACTIVE_LOW=0 -> off = all 0, lit bits high; one-hot dig_en checked every cycle.
